// File: rtl/dual_channel_frame_mixer_pkg.sv
// Shared constants, state encoding and word classifiers for the dual channel frame mixer.
package dual_channel_frame_mixer_pkg;

  localparam int unsigned DATA_WIDTH = 64;

  // Marker values carried in the top byte (header) and the bottom byte (footer) of a word.
  localparam logic [7:0] HEADER_ID = 8'hFF;
  localparam logic [7:0] FOOTER_ID = 8'h0F;

  // Head word presented by an empty FWFT FIFO; never appears inside a legal frame.
  localparam logic [DATA_WIDTH-1:0] EMPTY_WORD = {8'h00, {(DATA_WIDTH - 8){1'b1}}};

  typedef enum logic [1:0] {
    StIdle,
    StSendCh0,
    StSendCh1
  } state_e;

  function automatic logic is_header(input logic [DATA_WIDTH-1:0] word);
    return word[DATA_WIDTH-1 -: 8] == HEADER_ID;
  endfunction

  function automatic logic is_footer(input logic [DATA_WIDTH-1:0] word);
    return word[7:0] == FOOTER_ID;
  endfunction

endpackage

// File: rtl/dual_channel_frame_mixer_if.sv
// Bundle of the two FIFO-side channels plus the downstream word stream.
// The mixer takes the slave view; whatever feeds and drains it takes the master view.
interface dual_channel_frame_mixer_if;
  import dual_channel_frame_mixer_pkg::*;

  logic [DATA_WIDTH-1:0] ch0_din;
  logic                  ch0_read_request;
  logic                  ch0_re;
  logic [DATA_WIDTH-1:0] ch1_din;
  logic                  ch1_read_request;
  logic                  ch1_re;
  logic                  ready;
  logic [DATA_WIDTH-1:0] dout;
  logic                  sending;

  modport master (
    output ch0_din,
    output ch0_read_request,
    input  ch0_re,
    output ch1_din,
    output ch1_read_request,
    input  ch1_re,
    output ready,
    input  dout,
    input  sending
  );

  modport slave (
    input  ch0_din,
    input  ch0_read_request,
    output ch0_re,
    input  ch1_din,
    input  ch1_read_request,
    output ch1_re,
    input  ready,
    output dout,
    output sending
  );

endinterface

// File: rtl/dual_channel_frame_mixer_arbiter.sv
// Two-request round-robin grant. The priority pointer only moves when both channels
// contend, so a lone requester does not steal the next tie-break from the other channel.
module mixer_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       prio
);

  // 0: channel 0 wins the next tie, 1: channel 1 wins it.
  logic prio_q, prio_d;

  // Grant decode and pointer update on contention.
  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          gnt    = prio_q ? 2'b10 : 2'b01;
          prio_d = ~prio_q;
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio = prio_q;

endmodule

// File: rtl/dual_channel_frame_mixer.sv
// Merges whole frames from two FWFT channel FIFOs into one registered word stream.
// A granted frame runs from header to footer without interleaving; stalls on READY
// low or an empty FIFO hold the state so the frame resumes where it stopped.
module dual_channel_frame_mixer
  import dual_channel_frame_mixer_pkg::*;
(
  input logic                      clk,
  input logic                      reset,
  dual_channel_frame_mixer_if.slave bus
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  sending_q, sending_d;
  logic                  ch0_pop, ch1_pop;
  logic                  arb_en;
  logic [1:0]            gnt;
  logic                  prio;

  mixer_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   ({bus.ch1_read_request, bus.ch0_read_request}),
    .gnt   (gnt),
    .prio  (prio)
  );

  // Frame FSM next state, pop strobes and next output word.
  always_comb begin
    state_d = state_q;
    ch0_pop = 1'b0;
    ch1_pop = 1'b0;
    arb_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Arbitration ignores READY; popping only starts once a channel is granted.
        arb_en = 1'b1;
        if (gnt[0]) begin
          state_d = StSendCh0;
        end else if (gnt[1]) begin
          state_d = StSendCh1;
        end
      end
      StSendCh0: begin
        ch0_pop = bus.ready && (bus.ch0_din != EMPTY_WORD);
        if (ch0_pop && is_footer(bus.ch0_din)) begin
          state_d = StIdle;
        end
      end
      StSendCh1: begin
        ch1_pop = bus.ready && (bus.ch1_din != EMPTY_WORD);
        if (ch1_pop && is_footer(bus.ch1_din)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A reset cycle must leave the FIFOs untouched.
    if (reset) begin
      ch0_pop = 1'b0;
      ch1_pop = 1'b0;
    end

    dout_d    = EMPTY_WORD;
    sending_d = ch0_pop || ch1_pop;
    if (ch0_pop) begin
      dout_d = bus.ch0_din;
    end else if (ch1_pop) begin
      dout_d = bus.ch1_din;
    end
  end

  // State and registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      dout_q    <= EMPTY_WORD;
      sending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      sending_q <= sending_d;
    end
  end

  assign bus.ch0_re  = ch0_pop;
  assign bus.ch1_re  = ch1_pop;
  assign bus.dout    = dout_q;
  assign bus.sending = sending_q;

endmodule

// File: tb/tb_dual_channel_frame_mixer.sv
// Directed bench for the dual channel frame mixer: FWFT FIFO models on both channels,
// an output capture on the falling edge, and immediate-assertion checks in one sequence.
module tb_dual_channel_frame_mixer;
  import dual_channel_frame_mixer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dual_channel_frame_mixer_if bus ();

  dual_channel_frame_mixer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // FWFT FIFO models: written by the stimulus, popped on RE.
  logic [63:0] mem0 [0:255];
  logic [63:0] mem1 [0:255];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  logic empty0 = 1'b0;

  assign bus.ch0_din = (rd0 < wr0 && !empty0) ? mem0[rd0[7:0]] : EMPTY_WORD;
  assign bus.ch1_din = (rd1 < wr1) ? mem1[rd1[7:0]] : EMPTY_WORD;

  always @(posedge clk) begin
    if (bus.ch0_re) rd0 <= rd0 + 1;
    if (bus.ch1_re) rd1 <= rd1 + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid output word with the cycle it appeared in.
  logic [63:0] cap [0:511];
  int cap_cyc [0:511];
  int cap_n = 0;
  always @(negedge clk) begin
    if (bus.sending) begin
      cap[cap_n[8:0]]     <= bus.dout;
      cap_cyc[cap_n[8:0]] <= cyc;
      cap_n               <= cap_n + 1;
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic check_word(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  task automatic check_int(input string name, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word k of a frame with n data words: 0 is the header, n+1 the footer.
  function automatic logic [63:0] fw(input int c, input int tag, input int k, input int n);
    if (k == 0) return {8'hFF, 4'(c), 20'(tag), 24'h0, 8'h00};
    if (k == n + 1) return {20'hF80AF, 4'(c), 32'(tag), 8'h0F};
    return {4'(c), 8'(k), 48'h80A80A80A80A, 4'h0};
  endfunction

  task automatic push(input int c, input int tag, input int n);
    for (int k = 0; k <= n + 1; k++) begin
      if (c == 0) begin
        mem0[wr0[7:0]] = fw(c, tag, k, n);
        wr0++;
      end else begin
        mem1[wr1[7:0]] = fw(c, tag, k, n);
        wr1++;
      end
    end
  endtask

  task automatic wait_cap(input int target, input int budget, input string name);
    int n = 0;
    while (cap_n < target && n < budget) begin
      tick();
      n++;
    end
    check_int(name, cap_n, target);
  endtask

  task automatic wait_state(input state_e s, input int budget, input string name);
    int n = 0;
    while (dut.state_q != s && n < budget) begin
      tick();
      n++;
    end
    check_int(name, int'(dut.state_q), int'(s));
  endtask

  task automatic check_frame(input int base, input int c, input int tag, input int n,
                             input string name);
    for (int k = 0; k <= n + 1; k++) begin
      check_word($sformatf("%s[%0d]", name, k), cap[base + k], fw(c, tag, k, n));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int req_cyc;
    int rd0_snap;
    int rd1_snap;

    reset                = 1'b1;
    bus.ready            = 1'b0;
    bus.ch0_read_request = 1'b0;
    bus.ch1_read_request = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    check_word("rst_dout", bus.dout, 64'h00FF_FFFF_FFFF_FFFF);
    check_int("rst_sending", int'(bus.sending), 0);
    check_int("rst_re0", int'(bus.ch0_re), 0);
    check_int("rst_re1", int'(bus.ch1_re), 0);
    check_int("rst_state", int'(dut.state_q), int'(StIdle));
    check_int("rst_prio", int'(dut.u_arb.prio_q), 0);

    // 1: ch0 only, READY high, 41 data words.
    push(0, 1, 41);
    base                 = cap_n;
    req_cyc              = cyc;
    bus.ch0_read_request = 1'b1;
    bus.ready            = 1'b1;
    tick();
    bus.ch0_read_request = 1'b0;
    wait_cap(base + 43, 100, "t1_count");
    tick();
    tick();
    tick();
    check_int("t1_exact_count", cap_n - base, 43);
    check_int("t1_latency", cap_cyc[base] - req_cyc, 2);
    check_int("t1_contiguous", cap_cyc[base + 42] - cap_cyc[base], 42);
    check_frame(base, 0, 1, 41, "t1");
    check_int("t1_idle", int'(dut.state_q), int'(StIdle));
    check_int("t1_sending_low", int'(bus.sending), 0);

    // 2: simultaneous requests from reset, ch0 first.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push(0, 2, 3);
    push(1, 2, 3);
    base                 = cap_n;
    bus.ch0_read_request = 1'b1;
    bus.ch1_read_request = 1'b1;
    tick();
    bus.ch0_read_request = 1'b0;
    check_int("t2_first_grant", int'(dut.state_q), int'(StSendCh0));
    wait_state(StSendCh1, 50, "t2_second_grant");
    bus.ch1_read_request = 1'b0;
    wait_cap(base + 10, 50, "t2_count");
    check_frame(base, 0, 2, 3, "t2_ch0");
    check_frame(base + 5, 1, 2, 3, "t2_ch1");
    check_int("t2_idle_gap", int'(cap_cyc[base + 5] - cap_cyc[base + 4] >= 2), 1);
    check_int("t2_prio", int'(dut.u_arb.prio_q), 1);

    push(0, 3, 1);
    push(1, 3, 1);
    base                 = cap_n;
    bus.ch0_read_request = 1'b1;
    bus.ch1_read_request = 1'b1;
    tick();
    bus.ch1_read_request = 1'b0;
    check_int("t2b_first_grant", int'(dut.state_q), int'(StSendCh1));
    wait_state(StSendCh0, 50, "t2b_second_grant");
    bus.ch0_read_request = 1'b0;
    wait_cap(base + 6, 50, "t2b_count");
    check_frame(base, 1, 3, 1, "t2b_ch1");
    check_frame(base + 3, 0, 3, 1, "t2b_ch0");

    // 3: READY low for 10 cycles mid-frame.
    push(0, 4, 6);
    base                 = cap_n;
    bus.ch0_read_request = 1'b1;
    tick();
    bus.ch0_read_request = 1'b0;
    tick();
    tick();
    tick();
    bus.ready = 1'b0;
    #1;
    check_int("t3_re_gap_start", int'(bus.ch0_re), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_int($sformatf("t3_re[%0d]", i), int'(bus.ch0_re), 0);
      check_int($sformatf("t3_sending[%0d]", i), int'(bus.sending), 0);
      check_word($sformatf("t3_dout[%0d]", i), bus.dout, 64'h00FF_FFFF_FFFF_FFFF);
    end
    bus.ready = 1'b1;
    wait_cap(base + 8, 50, "t3_count");
    tick();
    tick();
    check_int("t3_exact_count", cap_n - base, 8);
    check_int("t3_resume_gap", cap_cyc[base + 3] - cap_cyc[base + 2], 11);
    check_frame(base, 0, 4, 6, "t3");

    // 4: ch0 FIFO runs empty for 5 cycles mid-frame.
    push(0, 5, 6);
    base                 = cap_n;
    bus.ch0_read_request = 1'b1;
    tick();
    bus.ch0_read_request = 1'b0;
    tick();
    tick();
    empty0 = 1'b1;
    #1;
    check_int("t4_re_empty", int'(bus.ch0_re), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_int($sformatf("t4_re[%0d]", i), int'(bus.ch0_re), 0);
      check_int($sformatf("t4_sending[%0d]", i), int'(bus.sending), 0);
    end
    check_int("t4_state_held", int'(dut.state_q), int'(StSendCh0));
    empty0 = 1'b0;
    wait_cap(base + 8, 50, "t4_count");
    check_frame(base, 0, 5, 6, "t4");
    wait_state(StIdle, 5, "t4_idle");

    // 5: ch0 request drops after the header; ch1 raised mid-frame waits for the footer.
    push(0, 6, 4);
    push(1, 6, 2);
    base                 = cap_n;
    bus.ch0_read_request = 1'b1;
    tick();
    tick();
    bus.ch0_read_request = 1'b0;
    bus.ch1_read_request = 1'b1;
    tick();
    check_int("t5_ch1_re_blocked", int'(bus.ch1_re), 0);
    check_int("t5_state_ch0", int'(dut.state_q), int'(StSendCh0));
    wait_state(StSendCh1, 50, "t5_ch1_grant");
    bus.ch1_read_request = 1'b0;
    wait_cap(base + 10, 50, "t5_count");
    check_frame(base, 0, 6, 4, "t5_ch0");
    check_frame(base + 6, 1, 6, 2, "t5_ch1");

    // 6: RESET mid-frame after a contended grant moved the priority.
    push(0, 7, 10);
    push(1, 7, 2);
    bus.ch0_read_request = 1'b1;
    bus.ch1_read_request = 1'b1;
    tick();
    bus.ch0_read_request = 1'b0;
    bus.ch1_read_request = 1'b0;
    check_int("t6_prio_moved", int'(dut.u_arb.prio_q), 1);
    tick();
    tick();
    tick();
    reset    = 1'b1;
    rd0_snap = rd0;
    rd1_snap = rd1;
    tick();
    check_word("t6_dout", bus.dout, 64'h00FF_FFFF_FFFF_FFFF);
    check_int("t6_sending", int'(bus.sending), 0);
    check_int("t6_re0", int'(bus.ch0_re), 0);
    check_int("t6_re1", int'(bus.ch1_re), 0);
    check_int("t6_state", int'(dut.state_q), int'(StIdle));
    check_int("t6_prio", int'(dut.u_arb.prio_q), 0);
    check_int("t6_fifo0_untouched", rd0, rd0_snap);
    check_int("t6_fifo1_untouched", rd1, rd1_snap);
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
